bp_fe_queue_buffer: RTL and testbench
=====================================

# bp_fe_queue_buffer

Circular buffer between the frontend PC generation stage and the backend that holds fetched-instruction and exception messages. It absorbs the fe_queue handshake from the frontend, presents messages in order to the backend through a valid/yumi interface, and is cleared in one cycle whenever the backend redirects the frontend.

## Interface
Parameters:
- bp_params_p, e_bp_inv_cfg: processor configuration; supplies vaddr/paddr/asid/branch-metadata widths.
- els_p, 8: entry count; power of two, at least 2.
- fe_queue_width_lp, derived: width of one fe_queue message, from the FE/BE interface declaration.
- ptr_width_lp, derived: $clog2(els_p).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  reset, asynchronous, active-high.
- clr_i  in  1  flush all entries; driven by the frontend on any non-attaboy FE command.
- fe_queue_i  in  fe_queue_width_lp  message from the PC generation stage.
- fe_queue_v_i  in  1  message valid; only legal while fe_queue_ready_o=1.
- fe_queue_ready_o  out  1  space available.
- fe_queue_o  out  fe_queue_width_lp  head message to the backend.
- fe_queue_v_o  out  1  head valid.
- fe_queue_yumi_i  in  1  backend consumes the head; only legal while fe_queue_v_o=1.
- count_o  out  ptr_width_lp+1  current occupancy.

## Operation
- Storage: els_p x fe_queue_width_lp register array. Read pointer and write pointer are each ptr_width_lp+1 bits; the MSB is a wrap bit.
- empty = (rptr == wptr); full = (low bits equal) & (wrap bits differ).
- Enqueue when fe_queue_v_i & fe_queue_ready_o & ~clr_i: write mem[wptr low bits], then wptr+1.
- Dequeue when fe_queue_yumi_i & ~clr_i: rptr+1.
- count_o = wptr - rptr, modulo 2^(ptr_width_lp+1).
- fe_queue_ready_o = ~full, registered through state only. A dequeue in the same cycle does not open space for an enqueue in that cycle.
- fe_queue_v_o = ~empty; fe_queue_o = mem[rptr low bits].
- clr_i takes priority. rptr and wptr are both set to 0 on the next edge. A same-cycle enqueue or dequeue is discarded. Array contents are not cleared.
- Simultaneous enqueue and dequeue with 0 < count < els_p: count is unchanged and both pointers advance.
- Pointer increments wrap naturally through the wrap bit. There is no special case at entry els_p-1.
- Illegal stimulus has no defined effect on state and is flagged by simulation assertions: v_i while ready_o=0, or yumi_i while v_o=0.

## Timing
- Reset: rptr=wptr=0, count_o=0, fe_queue_v_o=0, fe_queue_ready_o=1 (asynchronous, immediate on reset_i rising). The array is not reset; fe_queue_o is don't-care while v_o=0.
- Enqueue-to-visible latency is 1 cycle: an entry written at edge N gives fe_queue_v_o=1 in the cycle after edge N.
- Dequeue-to-next-head latency is 0 cycles after the edge: the next entry appears in the cycle following yumi.
- clr_i: v_o=0, count_o=0 and ready_o=1 in the cycle after the clr edge.
- Reset asserted mid-operation: all pointers return to 0 asynchronously. No messages survive.
- Full throughput is one enqueue and one dequeue per cycle.

## Configuration
- BP_FE_QUEUE_BYPASS_EN defined: when empty and fe_queue_v_i & ~clr_i, then fe_queue_o=fe_queue_i and fe_queue_v_o=1 combinationally. If fe_queue_yumi_i is also asserted that cycle, the message is not stored and the pointers are unchanged. Otherwise it is stored normally. This gives 0-cycle latency for an empty queue.
- BP_FE_QUEUE_BYPASS_EN not defined: no combinational path from fe_queue_i or fe_queue_v_i to the outputs. Latency is exactly 1 cycle as in Timing.

## Test plan
- Reset then idle: after reset_i deasserts, v_o=0, ready_o=1, count_o=0 for 10 cycles.
- Fill to full: enqueue 8 messages with payload 0x1..0x8 and no yumi. After 8 edges, ready_o=0 and count_o=8. Dequeue all 8; the order is 0x1..0x8 and ready_o=1 from the cycle after the first yumi.
- Wrap-around streaming: hold 3 entries, then enqueue and dequeue together every cycle for 40 cycles with an incrementing payload. count_o stays 3, output is in order, and no message is lost across the pointer wrap.
- Clear with collisions: at count_o=5, assert clr_i together with v_i (payload 0xAA) and yumi_i. Next cycle count_o=0 and v_o=0, and 0xAA never appears.
- Full plus dequeue: with count_o=8, assert yumi_i. ready_o stays 0 that cycle, count_o=7 next cycle, then ready_o=1.
- Bypass (only with BP_FE_QUEUE_BYPASS_EN): on an empty queue, v_i with payload 0x55 plus yumi_i in the same cycle gives fe_queue_o=0x55 and v_o=1 that cycle, and count_o stays 0. Without the macro, v_o=0 in that cycle.

Source files
------------

// File: rtl/bp_fe_queue_buffer.sv
// bp_fe_queue_buffer
// Circular message buffer between the frontend PC generation stage and the
// backend. It accepts fe_queue messages from the frontend and presents them
// in order to the backend over a valid/yumi handshake. A frontend redirect
// flushes it in one cycle.
// Optional build macro: BP_FE_QUEUE_BYPASS_EN. When defined, an empty queue
// passes an incoming message straight through to the backend in the same
// cycle.
// The message width normally follows the processor FE/BE configuration. Here
// it is an overridable parameter so the block stands on its own.
module bp_fe_queue_buffer #(
  parameter int els_p             = 8,
  parameter int fe_queue_width_lp = 32,
  localparam int ptr_width_lp     = $clog2(els_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clr_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,
  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_yumi_i,
  output logic [ptr_width_lp:0]        count_o
);

  localparam logic [ptr_width_lp:0] PtrOne = (ptr_width_lp+1)'(1);

  logic [fe_queue_width_lp-1:0] r_mem [els_p];
  logic [ptr_width_lp:0]        r_rptr;
  logic [ptr_width_lp:0]        r_wptr;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_enq;
  logic w_deq;

  // Occupancy flags. The pointer MSB is a wrap bit, so equal low bits mean
  // either empty (wrap bits match) or full (wrap bits differ).
  always_comb begin
    w_empty = (r_rptr == r_wptr);
    w_full  = (r_rptr[ptr_width_lp-1:0] == r_wptr[ptr_width_lp-1:0]) &&
              (r_rptr[ptr_width_lp] != r_wptr[ptr_width_lp]);
  end

`ifdef BP_FE_QUEUE_BYPASS_EN
  // An empty queue forwards a valid incoming message directly to the backend
  always_comb begin
    w_bypass = w_empty && fe_queue_v_i && !clr_i;
  end
`else
  // No bypass path. Every message spends at least one cycle in the array.
  always_comb begin
    w_bypass = 1'b0;
  end
`endif

  // Handshake qualification. A flush discards any same-cycle traffic. A
  // bypassed message that is consumed immediately is neither stored nor
  // dequeued. The ready term depends only on state, so a dequeue never frees
  // a slot for the same cycle.
  always_comb begin
    w_enq = fe_queue_v_i && !w_full && !clr_i && !(w_bypass && fe_queue_yumi_i);
    w_deq = fe_queue_yumi_i && !clr_i && !w_bypass;
  end

  // Pointer state. Increments wrap through the extra MSB. A flush or reset
  // returns both pointers to zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else if (clr_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PtrOne;
      if (w_deq) r_rptr <= r_rptr + PtrOne;
    end
  end

  // Message storage. It has no reset, and stale contents are hidden because
  // the valid output is derived from the pointers.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr[ptr_width_lp-1:0]] <= fe_queue_i;
  end

  // Backend and frontend facing outputs
  always_comb begin
    fe_queue_ready_o = !w_full;
    count_o          = r_wptr - r_rptr;
    fe_queue_v_o     = !w_empty || w_bypass;
    fe_queue_o       = w_bypass ? fe_queue_i : r_mem[r_rptr[ptr_width_lp-1:0]];
  end

`ifndef SYNTHESIS
  // Catch neighbouring stages that break the handshake rules
  a_no_v_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
    fe_queue_v_i |-> fe_queue_ready_o);
  a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    fe_queue_yumi_i |-> fe_queue_v_o);
`endif

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// tb_bp_fe_queue_buffer
// Scoreboard bench for bp_fe_queue_buffer. Stimulus pushes accepted messages
// into an expected-message queue. An independent negedge monitor compares
// occupancy, valid, ready and the head message against that queue.
// It also follows the BP_FE_QUEUE_BYPASS_EN build when that macro is defined.
module tb_bp_fe_queue_buffer;

  localparam int Els = 8;
  localparam int W   = 32;
`ifdef BP_FE_QUEUE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic          clk_i;
  logic          reset_i;
  logic          clr_i;
  logic [W-1:0]  fe_queue_i;
  logic          fe_queue_v_i;
  logic          fe_queue_ready_o;
  logic [W-1:0]  fe_queue_o;
  logic          fe_queue_v_o;
  logic          fe_queue_yumi_i;
  logic [3:0]    count_o;

  int            compared;
  int            mismatched;
  bit            running;
  logic [W-1:0]  expQ[$];
  logic [W-1:0]  payload;

  bp_fe_queue_buffer #(.els_p(Els), .fe_queue_width_lp(W)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .clr_i            (clr_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .count_o          (count_o)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Single comparison point that counts and reports every check
  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and update the scoreboard with what the edge accepts
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic y, input logic c);
    bit doEnq;
    int sz;
    sz = expQ.size();
    fe_queue_v_i    = v;
    fe_queue_i      = d;
    fe_queue_yumi_i = y;
    clr_i           = c;
    doEnq = v && (sz < Els) && !c && !(Bypass && sz == 0 && y);
    @(posedge clk_i);
    if (c) expQ.delete();
    else if (doEnq) expQ.push_back(d);
    #1;
  endtask

  // Monitor: occupancy flags every cycle, plus the head message on each consume
  always @(negedge clk_i) begin
    int  sz;
    bit  bypassNow;
    bit  expValid;
    if (running && !reset_i) begin
      sz        = expQ.size();
      bypassNow = Bypass && sz == 0 && fe_queue_v_i && !clr_i;
      expValid  = (sz != 0) || bypassNow;
      checkOutput("count", W'(count_o), W'(sz));
      checkOutput("valid", W'(fe_queue_v_o), W'(expValid));
      checkOutput("ready", W'(fe_queue_ready_o), W'(sz < Els));
      if (expValid && fe_queue_yumi_i && !clr_i) begin
        if (sz != 0) begin
          checkOutput("head", fe_queue_o, expQ[0]);
          void'(expQ.pop_front());
        end else begin
          checkOutput("bypass_data", fe_queue_o, fe_queue_i);
        end
      end
    end
  end

  // Directed scenarios followed by a randomized phase
  initial begin
    compared     = 0;
    mismatched   = 0;
    running      = 1'b0;
    payload      = '0;
    reset_i      = 1'b1;
    clr_i        = 1'b0;
    fe_queue_i   = '0;
    fe_queue_v_i = 1'b0;
    fe_queue_yumi_i = 1'b0;
    #11;
    checkOutput("reset_count", W'(count_o), '0);
    checkOutput("reset_valid", W'(fe_queue_v_o), '0);
    checkOutput("reset_ready", W'(fe_queue_ready_o), W'(1));
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    running = 1'b1;
    $display("[TB] idle after reset");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] fill to full then drain");
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] wrap-around streaming");
    payload = 32'h100;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, payload, 1'b0, 1'b0);
      payload++;
    end
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, payload, 1'b1, 1'b0);
      payload++;
    end

    $display("[TB] clear with colliding traffic");
    applyStimulus(1'b1, payload, 1'b0, 1'b0);
    applyStimulus(1'b1, payload + 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hAA, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] full plus dequeue");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h200 + W'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] empty-queue arrival with same-cycle consume");
    applyStimulus(1'b1, 32'h55, Bypass, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    while (expQ.size() != 0) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] asynchronous reset mid-operation");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h300 + W'(i), 1'b0, 1'b0);
    fe_queue_v_i    = 1'b0;
    fe_queue_yumi_i = 1'b0;
    clr_i           = 1'b0;
    #1 reset_i = 1'b1;
    #1;
    checkOutput("async_reset_count", W'(count_o), '0);
    checkOutput("async_reset_valid", W'(fe_queue_v_o), '0);
    checkOutput("async_reset_ready", W'(fe_queue_ready_o), W'(1));
    reset_i = 1'b0;
    expQ.delete();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 500; i++) begin
      logic v, y, c;
      int sz;
      sz = expQ.size();
      c = ($urandom_range(0, 19) == 0);
      v = (sz < Els) && ($urandom_range(0, 99) < 60);
      y = ((sz > 0) || (Bypass && v && !c)) && ($urandom_range(0, 99) < 50);
      applyStimulus(v, $urandom, y, c);
    end
    while (expQ.size() != 0) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
